stash_uart_dump: RTL
====================

# stash_uart_dump

Read-side companion to the sample stash: on a `start` pulse it walks the stash once, capturing the exposed sample and pulsing `next_sample`, and serialises every byte as UART 8N1 on `tx`. It sits between the stash's `sample_out`/`next_sample` pair and the board's USB-UART pin, so a full stash can be dumped to a PC. After a complete dump the stash read pointer is back where it started, because DEPTH advances wrap it exactly once.

## Interface
- `DEPTH`, default 5: number of bytes per dump. Must equal the stash DEPTH.
- `BAUD_DIV`, default 868: clk cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle dump request. Accepted only in IDLE.
- `sample`  in  8  stash `sample_out`.
- `stash_write`  in  1  monitor of the stash `sample_in_valid`.
- `next_sample`  out  1  one-cycle advance pulse to the stash.
- `tx`  out  1  UART line. Idle high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last stop bit of a complete dump.
- `aborted`  out  1  one-cycle pulse when a dump is cut short.

## Operation
- Reset values: `tx`=1, `next_sample`=0, `busy`=0, `done`=0, `aborted`=0. State is IDLE, all counters are 0, and `abort_pending` is 0. Reset mid-frame takes effect on the next edge: `tx` returns high at once and the partial frame is dropped.
- States: IDLE → CAPTURE → ADVANCE → START_BIT → DATA → STOP, then either back to CAPTURE, or to IDLE on the last byte or when an abort is pending.
- IDLE:
  - `start`=1 → CAPTURE, `byte_cnt`=0.
  - `start` while busy is ignored.
  - `stash_write` in IDLE is ignored; the stash simply re-points.
- CAPTURE (1 cycle):
  - If `abort_pending` or `stash_write` is high this cycle → IDLE. Pulse `aborted`, issue no `next_sample`, clear `abort_pending`.
  - Otherwise latch `sample` into `shift_reg`.
- ADVANCE (1 cycle): `next_sample`=1.
- START_BIT: `tx`=0 for BAUD_DIV cycles.
- DATA:
  - `tx`=`shift_reg[0]`, LSB first.
  - Shift right every BAUD_DIV cycles, 8 bits total. `bit_cnt` is 3 bits.
- STOP: `tx`=1 for BAUD_DIV cycles, then `byte_cnt`+1.
  - If `byte_cnt`+1 == DEPTH → IDLE and pulse `done`.
  - Else if `abort_pending` → IDLE and pulse `aborted`.
  - Else → CAPTURE.
- `stash_write` in any of ADVANCE, START_BIT, DATA or STOP sets `abort_pending`. The current frame always completes intact, with no truncated UART frames.
- If `stash_write` coincides with the final STOP exit, `done` takes priority and `aborted` stays 0.
- Widths:
  - `byte_cnt` is $clog2(DEPTH+1) bits.
  - The baud counter is $clog2(BAUD_DIV) bits and counts 0..BAUD_DIV-1 with wrap.

## Timing
- `start` at cycle 0 → CAPTURE at cycle 1, `next_sample` at cycle 2, `tx` falls at cycle 3.
- Per byte: 2 + 10·BAUD_DIV cycles.
- Full dump: DEPTH·(2 + 10·BAUD_DIV) cycles from CAPTURE entry to the `done` pulse.
- `done` and `aborted` are registered and occur in the cycle the FSM enters IDLE. `busy` falls in the same cycle.
- `sample` is sampled only in CAPTURE. It need only be stable combinationally in that cycle.
- Back-to-back dumps: `start` in the cycle after `done` is accepted.

## Structure
- Shared package/include `stash_dump_pkg`: state encodings (3-bit localparams) and the default BAUD_DIV constant.
- Sub-module `baud_timer`: parameter BAUD_DIV; inputs clk, reset, clear; output `tick`, high on the last cycle of each bit period. The FSM asserts `clear` on entry to START_BIT.
- `byte_cnt` may reuse the existing `Lim_Inc` with L=DEPTH-1.
- Everything else stays in the top module.

## Test plan
Bench setup: DEPTH=5, BAUD_DIV=4, with the stash model holding 0x11, 0x22, 0x33, 0x44, 0x55 and its read pointer at 0x11.
- Reset mid-DATA of byte 2 → next cycle `tx`=1, `busy`=0, no `done`; a fresh `start` dumps from the stash's current pointer.
- Single dump:
  - Decoded `tx` bytes are 0x11, 0x22, 0x33, 0x44, 0x55.
  - Exactly 5 `next_sample` pulses.
  - `done` arrives 5·42=210 cycles after CAPTURE entry.
  - The stash pointer is back at 0x11.
- Bit timing for 0xA5: after the start bit, `tx` reads 1,0,1,0,0,1,0,1, each held 4 cycles, then stop=1 for 4 cycles.
- `start` pulses during DATA are ignored. One extra `start` the cycle after `done` produces a second identical 5-byte dump.
- `stash_write` during DATA of byte 2:
  - Byte 2 (0x22) completes.
  - `aborted` pulses at STOP exit.
  - Only 2 `next_sample` pulses and no `done`.
- `stash_write` coinciding with CAPTURE of byte 3 → immediate `aborted`, no capture, no third `next_sample`, `tx` stays high.

Source files
------------

// File: rtl/stash_dump_pkg.sv
// stash_dump_pkg
// Shared definitions for the stash UART dump block: FSM state encoding and
// default parameter values.
//   state_t          : 3-bit FSM state encoding, also exposed on the debug port
//   DEFAULT_DEPTH    : default bytes per dump (must match the stash depth)
//   DEFAULT_BAUD_DIV : default clk cycles per UART bit (100 MHz / 115200)
package stash_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_ADVANCE   = 3'd2,
        ST_START_BIT = 3'd3,
        ST_DATA      = 3'd4,
        ST_STOP      = 3'd5
    } state_t;

    localparam int DEFAULT_DEPTH    = 5;
    localparam int DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/stash_uart_dump_baud_timer.sv
// baud_timer
// Free-running bit-period counter. Counts 0..BAUD_DIV-1 and wraps; tick_o is
// high on the last cycle of each bit period. clear_i restarts the count so the
// first period after it is a full BAUD_DIV cycles long.
// Ports:
//   clk     : clock
//   reset   : synchronous, active-high reset
//   clear_i : restart the bit period on the next edge
//   tick_o  : high in the last cycle of a bit period
module baud_timer
    import stash_dump_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/stash_uart_dump.sv
// stash_uart_dump
// Walks the sample stash once per start request and sends every byte as UART
// 8N1 (LSB first). For each byte: capture the exposed sample, pulse
// next_sample_o to advance the stash, then send start, 8 data and stop bits.
// A write into the stash during a dump lets the current frame finish and then
// aborts; a write seen in CAPTURE aborts before anything is sent.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start_i        : one-cycle dump request, honoured only in IDLE
//   sample_i       : stash sample_out, sampled only in CAPTURE
//   stash_write_i  : monitor of the stash write strobe
//   next_sample_o  : one-cycle stash advance pulse
//   tx_o           : UART line, idle high
//   busy_o         : high in every state except IDLE
//   done_o         : one-cycle pulse when a complete dump returns to IDLE
//   aborted_o      : one-cycle pulse when a dump is cut short
//   state_o        : current FSM state (debug)
module stash_uart_dump
    import stash_dump_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] sample_i,
    input  logic       stash_write_i,
    output logic       next_sample_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       aborted_o,
    output state_t     state_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH);

    state_t           state_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0] byte_cnt_d;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             abort_pending_q;
    logic             tx_q;
    logic             next_sample_q;
    logic             done_q;
    logic             aborted_q;
    logic             tick;
    logic             timer_clear;
    logic             write_in_frame;

    assign byte_cnt_d = byte_cnt_q + CNT_W'(1);

    // Clearing during ADVANCE makes the start bit the first full period.
    assign timer_clear = (state_q == ST_ADVANCE);

    // Writes while a frame is in flight are remembered, never acted on mid-frame.
    assign write_in_frame = stash_write_i &&
                            ((state_q == ST_ADVANCE) || (state_q == ST_START_BIT) ||
                             (state_q == ST_DATA)    || (state_q == ST_STOP));

    baud_timer #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_timer (
        .clk    (clk),
        .reset  (reset),
        .clear_i(timer_clear),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            byte_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            abort_pending_q <= 1'b0;
            tx_q            <= 1'b1;
            next_sample_q   <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            next_sample_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;

            // Later assignments in the case below override this on IDLE entry.
            if (write_in_frame) begin
                abort_pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (start_i) begin
                        state_q         <= ST_CAPTURE;
                        byte_cnt_q      <= '0;
                        abort_pending_q <= 1'b0;
                    end
                end

                ST_CAPTURE: begin
                    if (abort_pending_q || stash_write_i) begin
                        state_q         <= ST_IDLE;
                        aborted_q       <= 1'b1;
                        abort_pending_q <= 1'b0;
                    end else begin
                        shift_q       <= sample_i;
                        next_sample_q <= 1'b1;
                        state_q       <= ST_ADVANCE;
                    end
                end

                ST_ADVANCE: begin
                    tx_q    <= 1'b0;
                    state_q <= ST_START_BIT;
                end

                ST_START_BIT: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            // Present the next bit now so tx follows shift_q[0].
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        byte_cnt_q <= byte_cnt_d;
                        if (byte_cnt_d == LAST_CNT) begin
                            // Completion wins over a write arriving on the last edge.
                            state_q         <= ST_IDLE;
                            done_q          <= 1'b1;
                            abort_pending_q <= 1'b0;
                        end else if (abort_pending_q || stash_write_i) begin
                            state_q         <= ST_IDLE;
                            aborted_q       <= 1'b1;
                            abort_pending_q <= 1'b0;
                        end else begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign next_sample_o = next_sample_q;
    assign tx_o          = tx_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign state_o       = state_q;

endmodule
